// File: rtl/leaf_out_arbiter_if.sv
// Requester and output-lane handshake bundle for leaf_out_arbiter.
// master = environment side (requesters + leaf_interface); slave = arbiter side.
interface leaf_out_arbiter_if #(
    parameter int NUM_REQ      = 4,
    parameter int PAYLOAD_BITS = 32
);
    localparam int GID_W = $clog2(NUM_REQ);

    logic [NUM_REQ*PAYLOAD_BITS-1:0] in_data;
    logic [NUM_REQ-1:0]              in_vld;
    logic [NUM_REQ-1:0]              in_ack;
    logic [PAYLOAD_BITS-1:0]         out_data;
    logic                            out_vld;
    logic                            out_ack;
    logic [GID_W-1:0]                grant_id;

    modport master (
        output in_data, in_vld, out_ack,
        input  in_ack, out_data, out_vld, grant_id
    );

    modport slave (
        input  in_data, in_vld, out_ack,
        output in_ack, out_data, out_vld, grant_id
    );
endinterface

// File: rtl/leaf_out_arbiter.sv
// Burst-locked round-robin arbiter onto one leaf_interface output lane with a one-entry output register.
// Optional statistics counters (stall_cnt, word_cnt) are built when LEAF_ARB_STATS_EN is defined.
module leaf_out_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int PAYLOAD_BITS = 32,
    parameter int BURST_LEN    = 8
`ifdef LEAF_ARB_STATS_EN
    ,
    parameter int CNT_BITS     = 16
`endif
) (
    input  logic                clk_user,
    input  logic                reset,
    leaf_out_arbiter_if.slave   bus
`ifdef LEAF_ARB_STATS_EN
    ,
    output logic [CNT_BITS-1:0] stall_cnt,
    output logic [CNT_BITS-1:0] word_cnt
`endif
);
    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(BURST_LEN + 1);
    localparam int unsigned NREQ_U = NUM_REQ;

    typedef enum logic {IDLE, BURST} state_t;

    state_t                  state, state_n;
    logic [PTR_W-1:0]        rr_ptr, rr_n;
    logic [PTR_W-1:0]        gnt, gnt_n;
    logic [PTR_W-1:0]        winner, load_idx;
    logic [CNT_W-1:0]        burst_cnt, cnt_n;
    logic                    any_vld, load_ok, load;
    logic [NUM_REQ-1:0]      ack;
    logic [PAYLOAD_BITS-1:0] out_data_q;
    logic                    out_vld_q;
    logic [PTR_W-1:0]        grant_id_q;

    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] i);
        if (int'(i) == NUM_REQ - 1) return '0;
        return i + 1'b1;
    endfunction

    // Rotating priority search starting at rr_ptr, wrapping at NUM_REQ.
    always_comb begin
        int unsigned idx;
        idx     = 0;
        winner  = rr_ptr;
        any_vld = 1'b0;
        for (int unsigned k = 0; k < NREQ_U; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NREQ_U) idx = idx - NREQ_U;
            if (!any_vld && bus.in_vld[idx]) begin
                any_vld = 1'b1;
                winner  = idx[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        state_n  = state;
        rr_n     = rr_ptr;
        gnt_n    = gnt;
        cnt_n    = burst_cnt;
        load     = 1'b0;
        load_idx = gnt;
        ack      = '0;
        load_ok  = !out_vld_q || bus.out_ack;
        case (state)
            IDLE: begin
                if (any_vld && load_ok) begin
                    load     = 1'b1;
                    load_idx = winner;
                    gnt_n    = winner;
                    cnt_n    = CNT_W'(1);
                    if (BURST_LEN == 1) rr_n = wrap_inc(winner);
                    else                state_n = BURST;
                end
            end
            BURST: begin
                // A dropped valid ends the lock immediately, costing one bubble.
                if (!bus.in_vld[gnt]) begin
                    state_n = IDLE;
                    rr_n    = wrap_inc(gnt);
                end else if (load_ok) begin
                    load  = 1'b1;
                    cnt_n = burst_cnt + 1'b1;
                    if (cnt_n == CNT_W'(BURST_LEN)) begin
                        state_n = IDLE;
                        rr_n    = wrap_inc(gnt);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        if (reset) load = 1'b0;
        if (load) ack[load_idx] = 1'b1;
    end

    always_ff @(posedge clk_user) begin
        if (reset) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            gnt        <= '0;
            burst_cnt  <= '0;
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
            grant_id_q <= '0;
        end else begin
            state     <= state_n;
            rr_ptr    <= rr_n;
            gnt       <= gnt_n;
            burst_cnt <= cnt_n;
            if (load) begin
                out_data_q <= bus.in_data[load_idx*PAYLOAD_BITS +: PAYLOAD_BITS];
                grant_id_q <= load_idx;
                out_vld_q  <= 1'b1;
            end else if (bus.out_ack) begin
                out_vld_q <= 1'b0;
            end
        end
    end

    assign bus.in_ack   = ack;
    assign bus.out_data = out_data_q;
    assign bus.out_vld  = out_vld_q;
    assign bus.grant_id = grant_id_q;

`ifdef LEAF_ARB_STATS_EN
    always_ff @(posedge clk_user) begin
        if (reset) begin
            stall_cnt <= '0;
            word_cnt  <= '0;
        end else begin
            if (out_vld_q && !bus.out_ack && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
            if (out_vld_q && bus.out_ack) word_cnt <= word_cnt + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_leaf_out_arbiter.sv
// Directed bench for leaf_out_arbiter: three parameter sets (4x8, 4x2, 3x1) on one clock.
module tb_leaf_out_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    leaf_out_arbiter_if #(.NUM_REQ(4), .PAYLOAD_BITS(32)) bus_a ();
    leaf_out_arbiter_if #(.NUM_REQ(4), .PAYLOAD_BITS(32)) bus_b ();
    leaf_out_arbiter_if #(.NUM_REQ(3), .PAYLOAD_BITS(32)) bus_c ();

`ifdef LEAF_ARB_STATS_EN
    logic [15:0] stall_a, word_a, stall_b, word_b;
    logic [3:0]  stall_c, word_c;
`endif

    leaf_out_arbiter #(
        .NUM_REQ(4), .PAYLOAD_BITS(32), .BURST_LEN(8)
`ifdef LEAF_ARB_STATS_EN
        , .CNT_BITS(16)
`endif
    ) u_dut_a (
        .clk_user(clk), .reset(rst), .bus(bus_a)
`ifdef LEAF_ARB_STATS_EN
        , .stall_cnt(stall_a), .word_cnt(word_a)
`endif
    );

    leaf_out_arbiter #(
        .NUM_REQ(4), .PAYLOAD_BITS(32), .BURST_LEN(2)
`ifdef LEAF_ARB_STATS_EN
        , .CNT_BITS(16)
`endif
    ) u_dut_b (
        .clk_user(clk), .reset(rst), .bus(bus_b)
`ifdef LEAF_ARB_STATS_EN
        , .stall_cnt(stall_b), .word_cnt(word_b)
`endif
    );

    leaf_out_arbiter #(
        .NUM_REQ(3), .PAYLOAD_BITS(32), .BURST_LEN(1)
`ifdef LEAF_ARB_STATS_EN
        , .CNT_BITS(4)
`endif
    ) u_dut_c (
        .clk_user(clk), .reset(rst), .bus(bus_c)
`ifdef LEAF_ARB_STATS_EN
        , .stall_cnt(stall_c), .word_cnt(word_c)
`endif
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One cycle of instance A: drive at negedge, then check outputs 1ns later.
    task automatic step_a(input string tag, input logic r, input logic [3:0] vld,
                          input logic [31:0] d1, input logic [31:0] d3, input logic oack,
                          input logic [3:0] e_ack, input logic e_ov, input logic chk_od,
                          input logic [31:0] e_od, input logic [1:0] e_gid);
        @(negedge clk);
        rst                  = r;
        bus_a.in_vld         = vld;
        bus_a.in_data[32+:32] = d1;
        bus_a.in_data[96+:32] = d3;
        bus_a.out_ack        = oack;
        #1;
        check_eq({tag, "_ack"}, 64'(bus_a.in_ack), 64'(e_ack));
        check_eq({tag, "_ov"},  64'(bus_a.out_vld), 64'(e_ov));
        if (chk_od) begin
            check_eq({tag, "_od"},  64'(bus_a.out_data), 64'(e_od));
            check_eq({tag, "_gid"}, 64'(bus_a.grant_id), 64'(e_gid));
        end
    endtask

    initial begin
        bus_a.in_data = '0; bus_a.in_vld = '0; bus_a.out_ack = 1'b1;
        bus_b.in_data = '0; bus_b.in_vld = '0; bus_b.out_ack = 1'b1;
        bus_c.in_data = '0; bus_c.in_vld = '0; bus_c.out_ack = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_ov_a",  64'(bus_a.out_vld),  64'd0);
        check_eq("rst_od_a",  64'(bus_a.out_data), 64'd0);
        check_eq("rst_gid_a", 64'(bus_a.grant_id), 64'd0);
        check_eq("rst_ov_b",  64'(bus_b.out_vld),  64'd0);
        check_eq("rst_ov_c",  64'(bus_c.out_vld),  64'd0);
`ifdef LEAF_ARB_STATS_EN
        check_eq("rst_stall_a", 64'(stall_a), 64'd0);
        check_eq("rst_word_c",  64'(word_c),  64'd0);
`endif
        rst = 1'b0;

        // Single stream from requester 2: 0x10..0x17, one cycle latency, grant_id 2.
        for (int k = 0; k <= 9; k++) begin
            @(negedge clk);
            if (k < 8) begin
                bus_a.in_vld          = 4'b0100;
                bus_a.in_data[64+:32] = 32'h10 + 32'(k);
            end else begin
                bus_a.in_vld = '0;
            end
            #1;
            check_eq($sformatf("ss%0d_ack", k), 64'(bus_a.in_ack), (k < 8) ? 64'h4 : 64'h0);
            if (k >= 1 && k <= 8) begin
                check_eq($sformatf("ss%0d_ov", k),  64'(bus_a.out_vld),  64'd1);
                check_eq($sformatf("ss%0d_od", k),  64'(bus_a.out_data), 64'h10 + 64'(k - 1));
                check_eq($sformatf("ss%0d_gid", k), 64'(bus_a.grant_id), 64'd2);
            end
            if (k == 9) check_eq("ss9_ov", 64'(bus_a.out_vld), 64'd0);
        end

        // Backpressure, early release, reset mid-burst (rr_ptr is 3 here).
        //      tag    rst  vld      d1     d3     oack ack      ov  chk od     gid
        step_a("bp0",  0, 4'b0010, 32'h20, 32'h0,  1, 4'b0010, 0, 0, 32'h0,  2'd0);
        step_a("bp1",  0, 4'b0010, 32'h21, 32'h0,  0, 4'b0000, 1, 1, 32'h20, 2'd1);
`ifdef LEAF_ARB_STATS_EN
        check_eq("stall_start", 64'(stall_a), 64'd0);
`endif
        step_a("bp2",  0, 4'b0010, 32'h21, 32'h0,  0, 4'b0000, 1, 1, 32'h20, 2'd1);
        step_a("bp3",  0, 4'b0010, 32'h21, 32'h0,  0, 4'b0000, 1, 1, 32'h20, 2'd1);
        step_a("bp4",  0, 4'b0010, 32'h21, 32'h0,  0, 4'b0000, 1, 1, 32'h20, 2'd1);
        step_a("bp5",  0, 4'b0010, 32'h21, 32'h0,  0, 4'b0000, 1, 1, 32'h20, 2'd1);
        step_a("bp6",  0, 4'b0010, 32'h21, 32'h0,  1, 4'b0010, 1, 1, 32'h20, 2'd1);
`ifdef LEAF_ARB_STATS_EN
        check_eq("stall_five", 64'(stall_a), 64'd5);
`endif
        step_a("bp7",  0, 4'b0010, 32'h22, 32'h0,  1, 4'b0010, 1, 1, 32'h21, 2'd1);
        step_a("er8",  0, 4'b1000, 32'h0,  32'h30, 1, 4'b0000, 1, 1, 32'h22, 2'd1);
        step_a("er9",  0, 4'b1000, 32'h0,  32'h30, 1, 4'b1000, 0, 0, 32'h0,  2'd0);
        check_eq("er9_rr", 64'(u_dut_a.rr_ptr), 64'd2);
        step_a("er10", 0, 4'b1000, 32'h0,  32'h31, 1, 4'b1000, 1, 1, 32'h30, 2'd3);
        step_a("rs11", 1, 4'b1000, 32'h0,  32'h32, 1, 4'b0000, 1, 1, 32'h31, 2'd3);
        step_a("rs12", 0, 4'b1010, 32'h40, 32'h32, 1, 4'b0010, 0, 1, 32'h0,  2'd0);
        step_a("rs13", 0, 4'b1000, 32'h0,  32'h32, 1, 4'b0000, 1, 1, 32'h40, 2'd1);
        step_a("rs14", 0, 4'b0000, 32'h0,  32'h0,  1, 4'b0000, 0, 0, 32'h0,  2'd0);

        // Fairness with BURST_LEN=2: grants 0,0,1,1,2,2,3,3,0,0 without bubbles.
        for (int i = 0; i < 4; i++) bus_b.in_data[i*32 +: 32] = 32'hB0 + 32'(i);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            bus_b.in_vld = 4'b1111;
            #1;
            check_eq($sformatf("fair%0d_ack", k), 64'(bus_b.in_ack), 64'(1) << ((k / 2) % 4));
            if (k >= 1) begin
                check_eq($sformatf("fair%0d_ov", k),  64'(bus_b.out_vld),  64'd1);
                check_eq($sformatf("fair%0d_gid", k), 64'(bus_b.grant_id), 64'(((k - 1) / 2) % 4));
                check_eq($sformatf("fair%0d_od", k),  64'(bus_b.out_data), 64'hB0 + 64'(((k - 1) / 2) % 4));
            end
        end
        @(negedge clk);
        bus_b.in_vld = '0;

        // NUM_REQ=3, BURST_LEN=1: grants 0,1,2,0,...; 4-bit word_cnt wraps 15 -> 0.
        for (int i = 0; i < 3; i++) bus_c.in_data[i*32 +: 32] = 32'hC0 + 32'(i);
        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            bus_c.in_vld = 3'b111;
            #1;
            check_eq($sformatf("wrap%0d_ack", k), 64'(bus_c.in_ack), 64'(1) << (k % 3));
            if (k >= 1) begin
                check_eq($sformatf("wrap%0d_gid", k), 64'(bus_c.grant_id), 64'((k - 1) % 3));
                check_eq($sformatf("wrap%0d_od", k),  64'(bus_c.out_data), 64'hC0 + 64'((k - 1) % 3));
            end
`ifdef LEAF_ARB_STATS_EN
            if (k == 16) check_eq("word_15", 64'(word_c), 64'd15);
            if (k == 17) check_eq("word_wrap", 64'(word_c), 64'd0);
`endif
        end
        @(negedge clk);
        bus_c.in_vld = '0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/leaf_out_arbiter.md
# leaf_out_arbiter

Round-robin arbiter that shares one leaf-interface user→interface output port among NUM_REQ operator output streams, all using ap_vld/ap_ack handshakes. Sits in the leaf between the operator instances and one `din_leaf_user2interface`/`vld_user2interface`/`ack_interface2user` lane of `leaf_interface`, in the `clk_user` domain. Grants are locked for bursts of up to BURST_LEN words to keep same-source words contiguous. A one-entry output register decouples interface backpressure from the requesters.

## Interface
- NUM_REQ, 4, number of requesting streams (2..16)
- PAYLOAD_BITS, 32, word width; matches leaf_interface PAYLOAD_BITS
- BURST_LEN, 8, max words per grant (≥1)
- CNT_BITS, 16, statistics counter width (used only with LEAF_ARB_STATS_EN)

Ports:
- clk_user  in  1  user clock; single clock for the block
- reset  in  1  synchronous, active-high reset
- in_data  in  NUM_REQ*PAYLOAD_BITS  requester words; requester i at bits [i*PAYLOAD_BITS +: PAYLOAD_BITS]
- in_vld  in  NUM_REQ  requester word valid
- in_ack  out  NUM_REQ  word consumed this cycle (combinational, at most one bit high)
- out_data  out  PAYLOAD_BITS  word to leaf_interface
- out_vld  out  1  out_data valid
- out_ack  in  1  leaf_interface accepted out_data this cycle
- grant_id  out  clog2(NUM_REQ)  source index of the word in the output register
- stall_cnt  out  CNT_BITS  (LEAF_ARB_STATS_EN only) saturating count of cycles with out_vld=1, out_ack=0
- word_cnt  out  CNT_BITS  (LEAF_ARB_STATS_EN only) wrapping count of words delivered (out_vld & out_ack)

## Operation
- Handshake: a transfer occurs when vld and ack are both high in the same cycle. Requesters hold data/vld until acked.
- Output register: `load_ok = !out_vld | out_ack`. An input transfer happens only when load_ok. The accepted word and its index are written into out_data/grant_id, and out_vld=1. When out_ack=1 and no load occurs, out_vld clears. out_data and grant_id hold when out_vld=1 and out_ack=0.
- State IDLE:
  - The winner is the first i with in_vld[i]=1, searching from rr_ptr upward with wrap at NUM_REQ.
  - If any vld and load_ok: in_ack[winner]=1 (transfer), burst_cnt←1, gnt←winner.
  - Then, if BURST_LEN==1: stay IDLE, rr_ptr←(winner+1) mod NUM_REQ. Otherwise → BURST.
  - With no vld or !load_ok: no ack, state and rr_ptr unchanged.
- State BURST (grant locked to gnt):
  - in_ack[gnt] = in_vld[gnt] & load_ok. Other requesters are never acked.
  - On a transfer, burst_cnt++. When burst_cnt reaches BURST_LEN → IDLE, rr_ptr←gnt+1.
  - If in_vld[gnt]=0 in a cycle → IDLE, rr_ptr←gnt+1, no transfer that cycle.
  - While stalled (!load_ok with vld high), the lock is held and burst_cnt is unchanged.
- Arithmetic: burst_cnt is clog2(BURST_LEN+1) bits. rr_ptr wraps mod NUM_REQ, including non-power-of-2 values.
- Reset (any cycle, including mid-burst or with out_vld=1): state←IDLE, rr_ptr←0, burst_cnt←0, out_vld←0, out_data←0, grant_id←0, counters←0. in_ack is 0 during reset. A word held in the output register is discarded.

## Timing
- Latency: a word acked in cycle N appears on out_vld/out_data in cycle N+1.
- Throughput: 1 word/cycle sustained while out_ack=1, including at grant switches out of IDLE.
- One bubble cycle occurs when the locked requester drops vld mid-burst.
- in_ack depends combinationally on in_vld, out_vld, out_ack, and state. No combinational path from in_data to any output.
- Worst-case wait for a continuously valid requester: (NUM_REQ−1)·BURST_LEN transfers.

## Configuration
- LEAF_ARB_STATS_EN defined:
  - stall_cnt and word_cnt ports and registers exist.
  - stall_cnt saturates at all-ones. word_cnt wraps.
  - Both reset to 0.
- LEAF_ARB_STATS_EN undefined: the ports and logic are absent. Arbitration behaviour is identical in both builds.

## Test plan
- Single stream: NUM_REQ=4, in_vld[2]=1 with words 0x10..0x17, out_ack=1 → out_data 0x10..0x17 on consecutive cycles starting one cycle after the first ack, grant_id=2 throughout.
- Fairness: BURST_LEN=2, all four requesters always valid, out_ack=1 → grant_id sequence 0,0,1,1,2,2,3,3,0,0…, no bubbles.
- Backpressure: out_ack=0 for 5 cycles with out_vld=1 → out_data/grant_id stable, all in_ack=0, stall_cnt advances by 5 (stats build). Releasing out_ack resumes the same burst.
- Early release: requester 1 locked, drops vld after 3 of 8 words while requester 3 is valid → one bubble cycle, then grant_id=3, rr_ptr=2.
- Reset mid-burst: assert reset for 1 cycle with out_vld=1 during a burst → next cycle out_vld=0, out_data=0, in_ack=0. The first post-reset grant goes to the lowest valid index starting from 0.
- Wrap/non-power-of-2: NUM_REQ=3, BURST_LEN=1, all valid → grant_id 0,1,2,0,1,2. word_cnt at CNT_BITS=4 wraps 15→0.
